sram_sp_array: RTL and testbench

SRAM_SP_ARRAY -- requirements
Module: sram_sp_array

---
 rtl/sram_pkg.sv | 24 ++
 rtl/sram_sp_array_if.sv | 40 ++++
 rtl/sram_sp_core.sv | 80 ++++++++
 rtl/sram_sp_array.sv | 111 +++++++++++
 tb/tb_sram_sp_array.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_pkg.sv
// Shared definitions for the single-port SRAM array block.
//   state_e        : controller states (INIT sweep, RUN service)
//   addr_w()       : word-address width, at least one bit
//   read_lat_legal : accepted read-latency settings
package sram_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int READ_LAT_MIN = 1;
    localparam int READ_LAT_MAX = 2;

    // A two-word array still needs one address bit, so never return zero.
    function automatic int addr_w(input int depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

    function automatic bit read_lat_legal(input int lat);
        return (lat >= READ_LAT_MIN) && (lat <= READ_LAT_MAX);
    endfunction

endpackage

// File: rtl/sram_sp_array_if.sv
// Request/response bus of the single-port SRAM array.
//   req_valid/req_ready : request handshake (accepted when both high)
//   req_write           : 1 = masked write, 0 = read
//   req_addr            : word address
//   req_wmask/req_wdata : per-lane write enable and write data
//   resp_valid          : one-cycle read-data pulse
//   resp_rdata          : read data, held between responses
//   init_done           : array contents defined, requests accepted
// Modports: master drives requests, slave is the memory block.
interface sram_sp_array_if #(
    parameter int DATA_W    = 216,
    parameter int DEPTH     = 128,
    parameter int MASK_GRAN = 8
);
    import sram_pkg::*;

    localparam int AW     = addr_w(DEPTH);
    localparam int MASK_W = DATA_W / MASK_GRAN;

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [AW-1:0]     req_addr;
    logic [MASK_W-1:0] req_wmask;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              init_done;

    modport master (
        output req_valid, req_write, req_addr, req_wmask, req_wdata,
        input  req_ready, resp_valid, resp_rdata, init_done
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wmask, req_wdata,
        output req_ready, resp_valid, resp_rdata, init_done
    );

endinterface

// File: rtl/sram_sp_core.sv
// Storage array with one port, lane-masked write merge and a READ_LAT-stage
// read pipeline.
//   clock, reset : sole clock, synchronous active-high reset (pipeline only)
//   en, we       : port access enable, 1 = write / 0 = read
//   addr         : word address; addresses >= DEPTH write nothing, read zero
//   wmask, wdata : per-lane write enable and data
//   resp_valid   : read data valid, READ_LAT cycles after a read
//   resp_rdata   : read data, only updated together with resp_valid
module sram_sp_core
    import sram_pkg::*;
#(
    parameter int DATA_W    = 216,
    parameter int DEPTH     = 128,
    parameter int MASK_GRAN = 8,
    parameter int READ_LAT  = 1
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             en,
    input  logic                             we,
    input  logic [addr_w(DEPTH)-1:0]         addr,
    input  logic [DATA_W/MASK_GRAN-1:0]      wmask,
    input  logic [DATA_W-1:0]                wdata,
    output logic                             resp_valid,
    output logic [DATA_W-1:0]                resp_rdata
);
    localparam int AW     = addr_w(DEPTH);
    localparam int MASK_W = DATA_W / MASK_GRAN;
    localparam logic [AW:0] DEPTH_V = (AW + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [READ_LAT-1:0] pipe_v;
    logic [DATA_W-1:0]   pipe_d [READ_LAT];

    logic in_range;
    logic rd_en;

    // Extra bit so that DEPTH itself is representable when DEPTH = 2**AW.
    assign in_range = ({1'b0, addr} < DEPTH_V);
    assign rd_en    = en && !we;

    // NOTE: the array has no reset; the controller's init sweep defines every
    // word, and a reset branch here would turn the RAM into a register file.
    always_ff @(posedge clock) begin
        if (en && we && in_range) begin
            for (int k = 0; k < MASK_W; k++) begin
                if (wmask[k]) begin
                    mem[addr][k*MASK_GRAN +: MASK_GRAN] <= wdata[k*MASK_GRAN +: MASK_GRAN];
                end
            end
        end
    end

    // Each data stage only loads alongside its valid, so the last stage (the
    // visible read data) holds its value between responses.
    always_ff @(posedge clock) begin
        if (reset) begin
            pipe_v <= '0;
            for (int s = 0; s < READ_LAT; s++) begin
                pipe_d[s] <= '0;
            end
        end else begin
            pipe_v[0] <= rd_en;
            if (rd_en) begin
                pipe_d[0] <= in_range ? mem[addr] : '0;
            end
            for (int s = 1; s < READ_LAT; s++) begin
                pipe_v[s] <= pipe_v[s-1];
                if (pipe_v[s-1]) begin
                    pipe_d[s] <= pipe_d[s-1];
                end
            end
        end
    end

    assign resp_valid = pipe_v[READ_LAT-1];
    assign resp_rdata = pipe_d[READ_LAT-1];

endmodule

// File: rtl/sram_sp_array.sv
// Single-port SRAM array with init sweep and valid/ready request port.
// After reset the controller writes INIT_VAL to every word, one per cycle,
// then serves masked writes and fixed-latency reads.
//   clock : sole clock, rising edge
//   reset : synchronous, active-high
//   bus   : request/response bus (slave side), includes init_done
module sram_sp_array
    import sram_pkg::*;
#(
    parameter int                DATA_W    = 216,
    parameter int                DEPTH     = 128,
    parameter int                MASK_GRAN = 8,
    parameter int                READ_LAT  = 1,
    parameter logic [DATA_W-1:0] INIT_VAL  = '0
) (
    input  logic           clock,
    input  logic           reset,
    sram_sp_array_if.slave bus
);
    localparam int AW     = addr_w(DEPTH);
    localparam int MASK_W = DATA_W / MASK_GRAN;
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    if (!read_lat_legal(READ_LAT)) begin : g_bad_read_lat
        $error("sram_sp_array: READ_LAT must be 1 or 2");
    end
    if ((DATA_W % MASK_GRAN) != 0) begin : g_bad_mask_gran
        $error("sram_sp_array: DATA_W must be a multiple of MASK_GRAN");
    end
    if (DEPTH < 2) begin : g_bad_depth
        $error("sram_sp_array: DEPTH must be at least 2");
    end

    state_e        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;

    logic              core_en;
    logic              core_we;
    logic [AW-1:0]     core_addr;
    logic [MASK_W-1:0] core_wmask;
    logic [DATA_W-1:0] core_wdata;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, matching the hardware.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: every output of this block is given a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        core_en    = 1'b0;
        core_we    = 1'b0;
        core_addr  = bus.req_addr;
        core_wmask = bus.req_wmask;
        core_wdata = bus.req_wdata;
        case (state_q)
            ST_INIT: begin
                // The sweep owns the port; incoming requests are ignored.
                core_en    = 1'b1;
                core_we    = 1'b1;
                core_addr  = cnt_q;
                core_wmask = '1;
                core_wdata = INIT_VAL;
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                core_en = bus.req_valid;
                core_we = bus.req_write;
            end
            default: begin
                state_d = ST_INIT;
                cnt_d   = '0;
            end
        endcase
    end

    assign bus.req_ready = (state_q == ST_RUN);
    assign bus.init_done = (state_q == ST_RUN);

    sram_sp_core #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .MASK_GRAN (MASK_GRAN),
        .READ_LAT  (READ_LAT)
    ) u_core (
        .clock      (clock),
        .reset      (reset),
        .en         (core_en),
        .we         (core_we),
        .addr       (core_addr),
        .wmask      (core_wmask),
        .wdata      (core_wdata),
        .resp_valid (bus.resp_valid),
        .resp_rdata (bus.resp_rdata)
    );

endmodule

// File: tb/tb_sram_sp_array.sv
// Self-checking bench for sram_sp_array. Three instances run the same
// stimulus: A (DEPTH 128, READ_LAT 1, INIT 0), B (DEPTH 128, READ_LAT 2,
// INIT 5A..), C (DEPTH 100, READ_LAT 1, INIT C3..). A behavioural model
// (word array + queue of expected responses) checks every output each cycle.
module tb_sram_sp_array;

    localparam int DW = 216;
    localparam int MG = 8;
    localparam int MW = DW / MG;
    localparam int AW = 7;
    localparam int N  = 3;

    localparam logic [DW-1:0] INIT_A = '0;
    localparam logic [DW-1:0] INIT_B = {27{8'h5A}};
    localparam logic [DW-1:0] INIT_C = {27{8'hC3}};

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic          s_valid = 1'b0;
    logic          s_write = 1'b0;
    logic [AW-1:0] s_addr  = '0;
    logic [MW-1:0] s_mask  = '0;
    logic [DW-1:0] s_data  = '0;

    sram_sp_array_if #(.DATA_W(DW), .DEPTH(128), .MASK_GRAN(MG)) if_a ();
    sram_sp_array_if #(.DATA_W(DW), .DEPTH(128), .MASK_GRAN(MG)) if_b ();
    sram_sp_array_if #(.DATA_W(DW), .DEPTH(100), .MASK_GRAN(MG)) if_c ();

    assign if_a.req_valid = s_valid;
    assign if_a.req_write = s_write;
    assign if_a.req_addr  = s_addr;
    assign if_a.req_wmask = s_mask;
    assign if_a.req_wdata = s_data;
    assign if_b.req_valid = s_valid;
    assign if_b.req_write = s_write;
    assign if_b.req_addr  = s_addr;
    assign if_b.req_wmask = s_mask;
    assign if_b.req_wdata = s_data;
    assign if_c.req_valid = s_valid;
    assign if_c.req_write = s_write;
    assign if_c.req_addr  = s_addr;
    assign if_c.req_wmask = s_mask;
    assign if_c.req_wdata = s_data;

    sram_sp_array #(.DATA_W(DW), .DEPTH(128), .MASK_GRAN(MG), .READ_LAT(1), .INIT_VAL(INIT_A))
        dut_a (.clock(clock), .reset(reset), .bus(if_a.slave));
    sram_sp_array #(.DATA_W(DW), .DEPTH(128), .MASK_GRAN(MG), .READ_LAT(2), .INIT_VAL(INIT_B))
        dut_b (.clock(clock), .reset(reset), .bus(if_b.slave));
    sram_sp_array #(.DATA_W(DW), .DEPTH(100), .MASK_GRAN(MG), .READ_LAT(1), .INIT_VAL(INIT_C))
        dut_c (.clock(clock), .reset(reset), .bus(if_c.slave));

    logic          rdy  [N];
    logic          done [N];
    logic          vld  [N];
    logic [DW-1:0] rd   [N];

    assign rdy[0] = if_a.req_ready;  assign done[0] = if_a.init_done;
    assign vld[0] = if_a.resp_valid; assign rd[0]   = if_a.resp_rdata;
    assign rdy[1] = if_b.req_ready;  assign done[1] = if_b.init_done;
    assign vld[1] = if_b.resp_valid; assign rd[1]   = if_b.resp_rdata;
    assign rdy[2] = if_c.req_ready;  assign done[2] = if_c.init_done;
    assign vld[2] = if_c.resp_valid; assign rd[2]   = if_c.resp_rdata;

    // ---------------- reference model ----------------
    typedef struct {
        longint        due;
        logic [DW-1:0] data;
    } exp_t;

    int            depth_m [N] = '{128, 128, 100};
    int            lat_m   [N] = '{1, 2, 1};
    logic [DW-1:0] init_m  [N];
    int            sweep   [N];
    logic [DW-1:0] mem     [N][128];
    logic [DW-1:0] last    [N];
    exp_t          q       [N][$];
    longint        cyc = 0;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Applies the request/reset rules at a rising edge.
    task automatic model_edge();
        cyc++;
        for (int d = 0; d < N; d++) begin
            if (reset) begin
                sweep[d] = 0;
                q[d].delete();
                last[d] = '0;
            end else if (sweep[d] < depth_m[d]) begin
                sweep[d]++;
                if (sweep[d] == depth_m[d]) begin
                    for (int a = 0; a < depth_m[d]; a++) mem[d][a] = init_m[d];
                end
            end else if (s_valid) begin
                if (s_write) begin
                    if (int'(s_addr) < depth_m[d]) begin
                        for (int k = 0; k < MW; k++) begin
                            if (s_mask[k]) mem[d][s_addr][k*MG +: MG] = s_data[k*MG +: MG];
                        end
                    end
                end else begin
                    q[d].push_back('{due: cyc + lat_m[d] - 1,
                                     data: (int'(s_addr) < depth_m[d]) ? mem[d][s_addr] : '0});
                end
            end
        end
    endtask

    task automatic check_outputs();
        for (int d = 0; d < N; d++) begin
            logic exp_rdy;
            logic exp_v;
            exp_rdy = (sweep[d] == depth_m[d]);
            exp_v   = (q[d].size() > 0) && (q[d][0].due == cyc);
            if (exp_v) begin
                last[d] = q[d][0].data;
                void'(q[d].pop_front());
            end
            check($sformatf("req_ready[%0d]", d), rdy[d], exp_rdy);
            check($sformatf("init_done[%0d]", d), done[d], exp_rdy);
            check($sformatf("resp_valid[%0d]", d), vld[d], exp_v);
            check($sformatf("resp_rdata[%0d]", d), rd[d], last[d]);
        end
    endtask

    task automatic step(input logic v, input logic w, input int a,
                        input logic [MW-1:0] m, input logic [DW-1:0] dat);
        s_valid = v;
        s_write = w;
        s_addr  = AW'(a);
        s_mask  = m;
        s_data  = dat;
        @(posedge clock);
        model_edge();
        @(negedge clock);
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, '0, '0);
    endtask

    // Holds a read request during the sweep and counts cycles until A is ready.
    task automatic sweep_len_a(input string name);
        int n;
        n = 0;
        while (!if_a.req_ready && n < 300) begin
            step(1'b1, 1'b0, 3, '0, '0);
            n++;
        end
        check(name, DW'(n), DW'(128));
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [223:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom(),
             $urandom(), $urandom(), $urandom()};
        return r[DW-1:0];
    endfunction

    // ---------------- directed vectors (instance A, INIT 0) ----------------
    typedef struct {
        logic          write;
        int            addr;
        logic [MW-1:0] mask;
        logic [DW-1:0] data;
        logic [DW-1:0] exp_a;
    } vec_t;

    vec_t tbl [10];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        init_m[0] = INIT_A;
        init_m[1] = INIT_B;
        init_m[2] = INIT_C;

        tbl[0] = '{1'b1,   5, 27'h0000001, {27{8'hAB}}, '0};
        tbl[1] = '{1'b0,   5, '0,          '0,          216'hAB};
        tbl[2] = '{1'b1,   9, '1,          {27{8'h3C}}, '0};
        tbl[3] = '{1'b0,   9, '0,          '0,          {27{8'h3C}}};
        tbl[4] = '{1'b1,   9, 27'h4000000, {27{8'h11}}, '0};
        tbl[5] = '{1'b0,   9, '0,          '0,          {8'h11, {26{8'h3C}}}};
        tbl[6] = '{1'b0,   0, '0,          '0,          '0};
        tbl[7] = '{1'b1, 127, 27'h0000003, {27{8'hFF}}, '0};
        tbl[8] = '{1'b0, 127, '0,          '0,          216'hFFFF};
        tbl[9] = '{1'b0,   5, '0,          '0,          216'hAB};

        // Reset release, sweep length, then read back every word.
        reset = 1'b1;
        idle(3);
        reset = 1'b0;
        sweep_len_a("sweep_len_after_reset");
        for (int a = 0; a < 128; a++) step(1'b1, 1'b0, a, '0, '0);
        idle(3);

        // Masked write, write-then-read, lane merge, upper address.
        for (int i = 0; i < 10; i++) begin
            step(1'b1, tbl[i].write, tbl[i].addr, tbl[i].mask, tbl[i].data);
            if (!tbl[i].write) begin
                check($sformatf("tbl%0d_valid_a", i), DW'(vld[0]), DW'(1));
                check($sformatf("tbl%0d_rdata_a", i), rd[0], tbl[i].exp_a);
            end
        end
        idle(3);

        // Out-of-range accesses on the DEPTH=100 instance.
        step(1'b1, 1'b1, 110, '1, {27{8'hEE}});
        step(1'b1, 1'b0, 110, '0, '0);
        check("oob_read_valid_c", DW'(vld[2]), DW'(1));
        check("oob_read_zero_c", rd[2], '0);
        step(1'b1, 1'b0, 99, '0, '0);
        check("last_word_c", rd[2], INIT_C);
        idle(3);

        // Randomised traffic, biased towards a small address window.
        for (int i = 0; i < 600; i++) begin
            int a;
            a = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 127);
            step($urandom_range(0, 4) != 0, $urandom_range(0, 9) < 4, a,
                 MW'(rand_data()), rand_data());
        end
        idle(3);

        // Reset with reads in flight: pending responses are dropped.
        step(1'b1, 1'b0, 1, '0, '0);
        step(1'b1, 1'b0, 2, '0, '0);
        reset = 1'b1;
        step(1'b1, 1'b0, 4, '0, '0);
        check("no_resp_after_reset_b", DW'(vld[1]), DW'(0));
        reset = 1'b0;
        sweep_len_a("sweep_len_after_run_reset");

        // Reset in the middle of the sweep restarts it from word 0.
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        idle(40);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        sweep_len_a("sweep_len_after_mid_sweep_reset");
        for (int a = 0; a < 16; a++) step(1'b1, 1'b0, a * 7, '0, '0);
        idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
